rv32i_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the RV32I core. It shares a single memory bus between the instruction-fetch requester and the load/store requester, sequencing one transaction at a time with a req/ready handshake. It registers the response and aborts a stalled transaction after a bounded wait. It sits between the control unit's fetch/execute paths and the external instruction/data memory.

---
 rtl/rv32i_mem_arbiter_if.sv | 49 ++++
 rtl/rv32i_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle for rv32i_mem_arbiter: fetch port, load/store port, memory port.
// slave = arbiter side, master = requesters plus memory side.
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ready;
  logic                  if_err;

  logic                  ls_req;
  logic                  ls_we;
  logic [BW-1:0]         ls_be;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_ready;
  logic                  ls_err;

  logic                  mem_req;
  logic                  mem_we;
  logic [BW-1:0]         mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_ready, if_err,
    output ls_rdata, ls_ready, ls_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_ready, if_err,
    input  ls_rdata, ls_ready, ls_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Fetch vs load/store arbiter onto one memory bus, with response timeout.
// Define RV32I_ARB_ROUND_ROBIN_EN for round-robin ties (default: ls wins).
module rv32i_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst,
  rv32i_mem_arbiter_if.slave bus,
  output logic busy,
  output logic owner
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '1;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [BW-1:0]         mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_ready_q, if_ready_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  ls_ready_q, ls_ready_d;
  logic                  ls_err_q, ls_err_d;
  logic                  gnt_ls;
  logic                  tmo;

`ifdef RV32I_ARB_ROUND_ROBIN_EN
  assign gnt_ls = bus.ls_req & (~bus.if_req | ~owner_q);
`else
  assign gnt_ls = bus.ls_req;
`endif

  assign tmo = (TIMEOUT != 0) && (cnt_q == CMAX);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_ready_d  = 1'b0;
    if_err_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    ls_ready_d  = 1'b0;
    ls_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req | bus.ls_req) begin
          state_d   = BUS;
          owner_d   = gnt_ls;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (gnt_ls) begin
            mem_we_d    = bus.ls_we;
            mem_be_d    = bus.ls_be;
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      BUS: begin
        if (bus.mem_ready || tmo) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          // mem_ready beats a timeout landing in the same cycle
          if (owner_q) begin
            ls_ready_d = 1'b1;
            ls_err_d   = ~bus.mem_ready;
            ls_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            if_ready_d = 1'b1;
            if_err_d   = ~bus.mem_ready;
            if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      ls_ready_q  <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      if_err_q    <= if_err_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_ready_q  <= ls_ready_d;
      ls_err_q    <= ls_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_err    = if_err_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ls_ready  = ls_ready_q;
  assign bus.ls_err    = ls_err_q;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter (TIMEOUT=4 instance).
// Transaction-level model: winner, latency, err and data per request.
module tb_rv32i_mem_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic owner;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  bit own_m  = 1'b1;

  rv32i_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  rv32i_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ls_req    = 1'b0;
    bus.ls_we     = 1'b0;
    bus.ls_be     = '0;
    bus.ls_addr   = '0;
    bus.ls_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
  task automatic txn(input bit ir, input logic [31:0] ia,
                     input bit lr, input bit lwe,
                     input logic [3:0] lbe, input logic [31:0] la,
                     input logic [31:0] lwd, input int waits,
                     input logic [31:0] rdv);
    bit w, done, eerr;
    logic [31:0] ed, d, ea;
    logic ewe;
    logic [3:0] ebe;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.ls_req   = lr;
    bus.ls_we    = lwe;
    bus.ls_be    = lbe;
    bus.ls_addr  = la;
    bus.ls_wdata = lwd;
    chk("idle_busy", 32'(busy), 0);
`ifdef RV32I_ARB_ROUND_ROBIN_EN
    w = (ir && lr) ? ~own_m : lr;
`else
    w = lr;
`endif
    own_m = w;
    ea  = w ? la : ia;
    ewe = w ? lwe : 1'b0;
    ebe = w ? lbe : 4'hf;
    done = 0;
    eerr = 0;
    ed   = '0;
    @(negedge clk);
    for (int k = 0; k < 64 && !done; k++) begin
      chk("bus_mem_req", 32'(bus.mem_req), 1);
      chk("bus_busy", 32'(busy), 1);
      chk("bus_owner", 32'(owner), 32'(w));
      chk("bus_addr", bus.mem_addr, ea);
      chk("bus_we", 32'(bus.mem_we), 32'(ewe));
      chk("bus_be", 32'(bus.mem_be), 32'(ebe));
      if (w) chk("bus_wdata", bus.mem_wdata, lwd);
      bus.if_addr  = $urandom;
      bus.ls_addr  = $urandom;
      bus.ls_wdata = $urandom;
      bus.ls_be    = 4'($urandom);
      bus.ls_we    = 1'($urandom);
      d = (k == waits) ? rdv : $urandom;
      bus.mem_rdata = d;
      bus.mem_ready = (k == waits);
      if (k == waits) begin
        done = 1; eerr = 0; ed = d;
      end else if (k == TO - 1) begin
        done = 1; eerr = 1; ed = '0;
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    chk("resp_mem_req", 32'(bus.mem_req), 0);
    chk("resp_busy", 32'(busy), 1);
    if (w) begin
      chk("resp_ls_ready", 32'(bus.ls_ready), 1);
      chk("resp_ls_err", 32'(bus.ls_err), 32'(eerr));
      chk("resp_ls_rdata", bus.ls_rdata, ed);
      chk("resp_if_ready", 32'(bus.if_ready), 0);
      chk("resp_if_err", 32'(bus.if_err), 0);
      bus.ls_req = 1'b0;
    end else begin
      chk("resp_if_ready", 32'(bus.if_ready), 1);
      chk("resp_if_err", 32'(bus.if_err), 32'(eerr));
      chk("resp_if_rdata", bus.if_rdata, ed);
      chk("resp_ls_ready", 32'(bus.ls_ready), 0);
      chk("resp_ls_err", 32'(bus.ls_err), 0);
      bus.if_req = 1'b0;
    end
    @(negedge clk);
    chk("post_if_ready", 32'(bus.if_ready), 0);
    chk("post_ls_ready", 32'(bus.ls_ready), 0);
  endtask

  initial begin
    bit ir, lr;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    chk("rst_ready", 32'({bus.if_ready, bus.ls_ready}), 0);
    chk("rst_err", 32'({bus.if_err, bus.ls_err}), 0);
    chk("rst_rdata", bus.if_rdata | bus.ls_rdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 1);
    rst = 1'b0;
    @(negedge clk);

    // Both requesters held high across four transactions
    for (int i = 0; i < 4; i++)
      txn(1, 32'h0400_0000 + 32'(i * 4), 1, 0, 4'hf,
          32'h100 + 32'(i * 4), 0, 0, $urandom);

    // Fetch, zero wait states
    txn(1, 32'h0400_0000, 0, 0, 0, 0, 0, 0, 32'h0000_0013);
    // Store, 3 wait states: ready lands on the timeout cycle
    txn(0, 0, 1, 1, 4'b0011, 32'h10, 32'hDEAD_BEEF, 3, $urandom);
    // Timeout on both ports
    txn(1, 32'h2000, 0, 0, 0, 0, 0, 99, $urandom);
    txn(0, 0, 1, 0, 4'hf, 32'h3000, 0, 99, $urandom);

    // Reset in the middle of a bus cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0080;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_owner", 32'(owner), 1);
    bus.if_req = 1'b0;
    own_m = 1'b1;
    @(negedge clk);
    chk("arst_no_ready", 32'({bus.if_ready, bus.ls_ready}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_ready", 32'({bus.if_ready, bus.ls_ready}), 0);
    txn(1, 32'h0000_0080, 0, 0, 0, 0, 0, 1, 32'h1234_5678);

    // Randomized mix of requests, wait states and timeouts
    for (int i = 0; i < 40; i++) begin
      ir = 1'($urandom);
      lr = 1'($urandom);
      if (!ir && !lr) ir = 1'b1;
      txn(ir, $urandom, lr, 1'($urandom), 4'($urandom), $urandom,
          $urandom, int'($urandom_range(0, 6)), $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
